poly_power2round_seq: RTL and testbench

- Sequential controller that applies Dilithium Power2Round (D=13) to a 256-coefficient polynomial held in a synchronous RAM.
- Reads LANES coefficients per cycle and feeds them through LANES instances of the power2round cell.
- Writes the a0 and a1 results to two output RAM ports.
- Replaces the fully parallel 256-cell datapath in area-constrained key generation; start/done handshake toward the keygen FSM.

---
 rtl/poly_power2round_seq_pkg.sv | 25 ++
 rtl/poly_power2round_seq_p2r.sv | 21 ++
 rtl/poly_power2round_seq.sv | 157 +++++++++++++++
 tb/tb_poly_power2round_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_power2round_seq_pkg.sv
// Shared constants and types for the sequential Power2Round controller.
// Holds the polynomial geometry defaults (N, LANES), the Dilithium parameters
// (D, Q), the derived word count / address width and the controller state type.
package poly_power2round_seq_pkg;

    // Address width for a RAM of 'words' entries; never narrower than one bit.
    function automatic int addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int P2R_N     = 256;
    localparam int P2R_LANES = 4;
    localparam int P2R_D     = 13;
    localparam int P2R_Q     = 8380417;
    localparam int P2R_WORDS = P2R_N / P2R_LANES;
    localparam int P2R_AW    = addr_width(P2R_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } p2r_state_t;

endpackage

// File: rtl/poly_power2round_seq_p2r.sv
// Power2Round cell: splits a signed 32-bit coefficient into a1 (high part) and
// a0 (centred low part) with a == a1*2^D + a0. Purely combinational.
// Ports: i_a coefficient in; o_a1 = (a + 2^(D-1) - 1) >>> D; o_a0 = a - (a1 << D).
module poly_power2round_seq_p2r #(
    parameter int D = 13
) (
    input  logic signed [31:0] i_a,
    output logic signed [31:0] o_a0,
    output logic signed [31:0] o_a1
);

    // Rounding offset biases the split so a0 lands in (-2^(D-1), 2^(D-1)].
    localparam logic signed [31:0] RND = 32'((1 << (D - 1)) - 1);

    logic signed [31:0] w_rnd;

    assign w_rnd = i_a + RND;
    assign o_a1  = w_rnd >>> D;
    assign o_a0  = i_a - (o_a1 <<< D);

endmodule

// File: rtl/poly_power2round_seq.sv
// Sequential Power2Round over an N-coefficient polynomial stored LANES per RAM word.
// Ports: clk/rst (sync, active-high); start/busy/done handshake; rd_en/rd_addr/rd_data
// to the source RAM (1-cycle read); wr_en/wr_addr/a0_data/a1_data to the result RAMs;
// range_err sticky flag for any input coefficient outside [0, Q-1].
module poly_power2round_seq
    import poly_power2round_seq_pkg::*;
#(
    parameter  int N     = P2R_N,
    parameter  int LANES = P2R_LANES,
    parameter  int D     = P2R_D,
    parameter  int Q     = P2R_Q,
    localparam int WORDS = N / LANES,
    localparam int AW    = addr_width(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [32*LANES-1:0]   rd_data,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [32*LANES-1:0]   a0_data,
    output logic [32*LANES-1:0]   a1_data,
    output logic                  range_err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    p2r_state_t             r_state;
    p2r_state_t             w_next_state;
    logic                   w_issue;
    logic                   w_start_acc;

    logic [AW-1:0]          r_cnt;
    logic                   r_s1_vld;
    logic [AW-1:0]          r_s1_addr;
    logic                   r_wr_en;
    logic [AW-1:0]          r_wr_addr;
    logic [32*LANES-1:0]    r_a0;
    logic [32*LANES-1:0]    r_a1;
    logic                   r_range_err;

    logic [LANES-1:0]       w_lane_bad;
    logic [32*LANES-1:0]    w_a0_word;
    logic [32*LANES-1:0]    w_a1_word;

    // Next-state and read-issue decode.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_issue = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once the last word's write strobe is on the outputs.
                if (r_wr_en && (r_wr_addr == LAST_ADDR)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_start_acc = (r_state == ST_IDLE) && start;

    // Stage 1 is the RAM output register itself: r_s1_vld/r_s1_addr are the
    // read strobe and address delayed to line up with rd_data. The cells work
    // on rd_data directly and stage 2 registers their results.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [31:0]        w_lane;
        logic signed [31:0] w_a0;
        logic signed [31:0] w_a1;

        assign w_lane        = rd_data[32*g +: 32];
        // Sign bit set covers negatives; otherwise an unsigned compare is exact.
        assign w_lane_bad[g] = w_lane[31] | (w_lane >= 32'(Q));

        poly_power2round_seq_p2r #(
            .D(D)
        ) u_p2r (
            .i_a  (w_lane),
            .o_a0 (w_a0),
            .o_a1 (w_a1)
        );

        assign w_a0_word[32*g +: 32] = w_a0;
        assign w_a1_word[32*g +: 32] = w_a1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_a0        <= '0;
            r_a1        <= '0;
            r_range_err <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Counter wraps back to zero after the last word of a run.
            if (w_start_acc) begin
                r_cnt <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_s1_vld  <= w_issue;
            r_s1_addr <= r_cnt;

            r_wr_en <= r_s1_vld;
            if (r_s1_vld) begin
                r_wr_addr <= r_s1_addr;
                r_a0      <= w_a0_word;
                r_a1      <= w_a1_word;
            end

            // The pipeline is empty in IDLE, so clear and set never coincide.
            if (w_start_acc) begin
                r_range_err <= 1'b0;
            end else if (r_s1_vld && (|w_lane_bad)) begin
                r_range_err <= 1'b1;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign rd_en     = w_issue;
    assign rd_addr   = r_cnt;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign a0_data   = r_a0;
    assign a1_data   = r_a1;
    assign range_err = r_range_err;

endmodule

// File: tb/tb_poly_power2round_seq.sv
`timescale 1ns/1ps
module tb_poly_power2round_seq;

    localparam int LANES = 4;
    localparam int WORDS = 64;
    localparam int AW    = 6;
    localparam int W     = 32 * LANES;
    localparam int QV    = 8380417;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  a;
        logic [W-1:0]  a0;
        logic [W-1:0]  a1;
        logic          bad;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, rd_en, wr_en, range_err;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  rd_data = '0;
    logic [W-1:0]  a0_data, a1_data;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];

    logic [W-1:0] mem    [WORDS];
    logic [W-1:0] out_a0 [WORDS];
    logic [W-1:0] out_a1 [WORDS];

    int VEC0_IN [4] = '{0, 4096, 4097, 8380416};
    int VEC0_A1 [4] = '{0, 0, 1, 1023};
    int VEC0_A0 [4] = '{0, 4096, -4095, 0};
    int VEC1_IN [4] = '{12288, 8191, 8192, 1};
    int VEC1_A1 [4] = '{1, 1, 1, 0};
    int VEC1_A0 [4] = '{4096, -1, 0, 1};

    always #5 clk = ~clk;

    poly_power2round_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .a0_data   (a0_data),
        .a1_data   (a1_data),
        .range_err (range_err)
    );

    // Source RAM (1-cycle read) and result RAMs.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) begin
            out_a0[wr_addr] <= a0_data;
            out_a1[wr_addr] <= a1_data;
        end
    end

    // Reference: centred remainder mod 2^13, then a1 = (a - a0) / 2^13.
    function automatic logic [63:0] ref_lane(input logic [31:0] a);
        logic signed [31:0] r;
        logic signed [31:0] hi;
        r = $signed({19'd0, a[12:0]});
        if (r > 32'sd4096) r = r - 32'sd8192;
        hi = ($signed(a) - r) >>> 13;
        return {hi, r};
    endfunction

    // mode 0: test vectors in words 0/1; mode 1: word 17 lane 2 = Q;
    // mode 2: word 5 lane 0 = -1. All other lanes random in [0, Q-1].
    task automatic load_poly(input int mode, input bit push);
        logic [W-1:0]  word;
        logic [31:0]   v;
        logic [63:0]   r;
        exp_t          e;
        for (int w = 0; w < WORDS; w++) begin
            e.bad = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                v = 32'($urandom_range(0, QV - 1));
                if (mode == 0 && w == 0) v = 32'(VEC0_IN[l]);
                if (mode == 0 && w == 1) v = 32'(VEC1_IN[l]);
                if (mode == 1 && w == 17 && l == 2) v = 32'(QV);
                if (mode == 2 && w == 5 && l == 0) v = 32'hFFFF_FFFF;
                word[32*l +: 32] = v;
                r = ref_lane(v);
                e.a1[32*l +: 32] = r[63:32];
                e.a0[32*l +: 32] = r[31:0];
                if (v[31] || (v >= 32'(QV))) e.bad = 1'b1;
            end
            mem[w] = word;
            e.addr = AW'(w);
            e.a    = word;
            if (push) q.push_back(e);
        end
    endtask

    // Compare one DUT write against the scoreboard head.
    task automatic check_write(input string name, inout logic exp_rerr);
        exp_t e;
        logic ident_ok;
        logic signed [31:0] s0, s1, sa;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected write addr=%0d (scoreboard empty)", name, wr_addr);
        end else begin
            e = q.pop_front();
            exp_rerr = exp_rerr | e.bad;
            ident_ok = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                s0 = $signed(a0_data[32*l +: 32]);
                s1 = $signed(a1_data[32*l +: 32]);
                sa = $signed(e.a[32*l +: 32]);
                if (s1 * 32'sd8192 + s0 !== sa) ident_ok = 1'b0;
            end
            if (wr_addr !== e.addr || a0_data !== e.a0 || a1_data !== e.a1
                || !ident_ok || range_err !== exp_rerr) begin
                failures++;
                $display("FAIL %s write: addr=%0d a0=%h a1=%h rerr=%b ident=%b, expected addr=%0d a0=%h a1=%h rerr=%b",
                         name, wr_addr, a0_data, a1_data, range_err, ident_ok,
                         e.addr, e.a0, e.a1, exp_rerr);
            end
        end
    endtask

    // One full run from a start pulse; checks the cycle timeline and every write.
    task automatic do_run(input string name, input bit poke);
        logic [3:0] obs;
        logic [3:0] expv;
        logic       exp_rerr;
        exp_rerr = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start = 1'b0;
            expv = {(c <= 67), (c == 67), (c <= 64), (c >= 3 && c <= 66)};
            obs  = {busy, done, rd_en, wr_en};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL %s timeline cycle k+%0d {busy,done,rd_en,wr_en}=%b expected %b",
                         name, c, obs, expv);
            end
            if (rd_en) begin
                checks++;
                if (rd_addr !== AW'(c - 1)) begin
                    failures++;
                    $display("FAIL %s rd_addr cycle k+%0d got %0d expected %0d", name, c, rd_addr, c - 1);
                end
            end
            if (wr_en) check_write(name, exp_rerr);
            if (poke) start = (c >= 5 && c <= 60 && (c % 7) == 0);
        end
        checks++;
        if (q.size() != 0 || range_err !== exp_rerr) begin
            failures++;
            $display("FAIL %s end: leftover=%0d range_err=%b expected leftover=0 range_err=%b",
                     name, q.size(), range_err, exp_rerr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, wr_en, range_err} !== 5'b0 || rd_addr !== '0
            || wr_addr !== '0 || a0_data !== '0 || a1_data !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b rd_en=%b wr_en=%b rerr=%b rd_addr=%0d wr_addr=%0d a0=%h a1=%h, expected all zero",
                     busy, done, rd_en, wr_en, range_err, rd_addr, wr_addr, a0_data, a1_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lane_values();
        load_poly(0, 1'b1);
        do_run("lane_values", 1'b0);
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (out_a1[0][32*l +: 32] !== 32'(VEC0_A1[l]) || out_a0[0][32*l +: 32] !== 32'(VEC0_A0[l])) begin
                failures++;
                $display("FAIL vec0 lane %0d a1=%0d a0=%0d expected a1=%0d a0=%0d", l,
                         $signed(out_a1[0][32*l +: 32]), $signed(out_a0[0][32*l +: 32]), VEC0_A1[l], VEC0_A0[l]);
            end
            checks++;
            if (out_a1[1][32*l +: 32] !== 32'(VEC1_A1[l]) || out_a0[1][32*l +: 32] !== 32'(VEC1_A0[l])) begin
                failures++;
                $display("FAIL vec1 lane %0d a1=%0d a0=%0d expected a1=%0d a0=%0d", l,
                         $signed(out_a1[1][32*l +: 32]), $signed(out_a0[1][32*l +: 32]), VEC1_A1[l], VEC1_A0[l]);
            end
        end
    endtask

    task automatic test_range_err();
        load_poly(1, 1'b1);
        do_run("range_err", 1'b1);
        checks++;
        if (range_err !== 1'b1) begin
            failures++;
            $display("FAIL range_err sticky got %b expected 1", range_err);
        end
        load_poly(0, 1'b1);
        do_run("range_clear", 1'b0);
    endtask

    task automatic test_mid_reset();
        load_poly(2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 30) begin
                checks++;
                if (range_err !== 1'b1 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL mid_reset pre: range_err=%b busy=%b expected 1 1", range_err, busy);
                end
                rst = 1'b1;
            end else if (c == 31) begin
                rst = 1'b0;
                checks++;
                if ({busy, done, rd_en, wr_en, range_err} !== 5'b0) begin
                    failures++;
                    $display("FAIL mid_reset post {busy,done,rd_en,wr_en,rerr}=%b expected 00000",
                             {busy, done, rd_en, wr_en, range_err});
                end
            end else if (c > 31) begin
                checks++;
                if ({busy, done, rd_en, wr_en} !== 4'b0) begin
                    failures++;
                    $display("FAIL mid_reset quiet cycle k+%0d {busy,done,rd_en,wr_en}=%b expected 0000",
                             c, {busy, done, rd_en, wr_en});
                end
            end
        end
        load_poly(0, 1'b1);
        do_run("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        exp_t one[$];
        int   done_at[$];
        logic exp_rerr;
        exp_rerr = 1'b0;
        load_poly(0, 1'b1);
        one = q;
        q = {q, one, one};
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            @(negedge clk);
            if (c == 200) start = 1'b0;
            if (done) done_at.push_back(c);
            if (wr_en) check_write("back_to_back", exp_rerr);
        end
        checks++;
        if (done_at.size() != 3 || q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back: done pulses=%0d leftover=%0d busy=%b expected 3 0 0",
                     done_at.size(), q.size(), busy);
        end else begin
            checks++;
            if (done_at[0] != 67 || done_at[1] != 135 || done_at[2] != 203) begin
                failures++;
                $display("FAIL back_to_back done cycles %0d %0d %0d expected 67 135 203",
                         done_at[0], done_at[1], done_at[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lane_values();
        test_range_err();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
